// File: rtl/banco_registros_param_pkg.sv
// Shared definitions for the parameterised register file: clear-FSM states
// and the offset the PC pseudo-register adds to the fetch address.
package banco_registros_param_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int PC_OFFSET = 8;

endpackage

// File: rtl/banco_read_port.sv
// One registered read port. The top address is not storage: it returns the
// fetch PC plus the fixed offset. A same-cycle write to the addressed storage
// register is forwarded so the port sees the new value (write-first).
module banco_read_port
  import banco_registros_param_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] rd
);

  localparam int               DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(DEPTH - 1);

  // Register the selected source: PC substitution first, then bypass, then storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
    end else if (ra == PC_ADDR) begin
      rd <= pc_in + DATA_W'(PC_OFFSET);
    end else if (wr_en && (wa == ra)) begin
      rd <= wd;
    end else begin
      rd <= stored;
    end
  end

endmodule

// File: rtl/banco_registros_param.sv
// Parameterised register file with N_RD registered read ports, one write
// port, a PC pseudo-register at the top address, and a sequential clear that
// zeroes one register per cycle while busy is high.
module banco_registros_param
  import banco_registros_param_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [N_RD*ADDR_W-1:0]   ra,
  output logic [N_RD*DATA_W-1:0]   rd,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     clr,
  output logic                     busy,
  output logic                     pc_wr,
  output logic [DATA_W-1:0]        pc_wd
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(DEPTH - 2);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH-1];
  logic              wr_ok;

  // A write counts only when idle and not losing to a simultaneous clear
  assign wr_ok = we && !busy && !clr;

  // Clear sequencer: walk the pointer over every storage register, then idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST_REG) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: clearing takes priority, the PC address is never stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (wr_ok && (wa != PC_ADDR)) begin
      regs[wa] <= wd;
    end
  end

  // A write aimed at the PC becomes a one-cycle redirect pulse for fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_wr <= 1'b0;
      pc_wd <= '0;
    end else begin
      pc_wr <= wr_ok && (wa == PC_ADDR);
      if (wr_ok && (wa == PC_ADDR)) begin
        pc_wd <= wd;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra_k;
      logic [DATA_W-1:0] stored_k;

      assign ra_k     = ra[k*ADDR_W +: ADDR_W];
      assign stored_k = regs[ra_k];

      banco_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_port (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra     (ra_k),
        .stored (stored_k),
        .wr_en  (wr_ok),
        .wa     (wa),
        .wd     (wd),
        .pc_in  (pc_in),
        .rd     (rd[k*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for the register file: a default-sized instance (A) and a
// DATA_W=16 / ADDR_W=3 / N_RD=3 instance (B) share clock and reset.
module tb_banco_registros_param;

  logic clk;
  logic rst_n;

  logic        we_a;
  logic [3:0]  wa_a;
  logic [31:0] wd_a;
  logic [7:0]  ra_a;
  logic [63:0] rd_a;
  logic [31:0] pc_in_a;
  logic        clr_a;
  logic        busy_a;
  logic        pc_wr_a;
  logic [31:0] pc_wd_a;

  logic        we_b;
  logic [2:0]  wa_b;
  logic [15:0] wd_b;
  logic [8:0]  ra_b;
  logic [47:0] rd_b;
  logic [15:0] pc_in_b;
  logic        clr_b;
  logic        busy_b;
  logic        pc_wr_b;
  logic [15:0] pc_wd_b;

  int total = 0;
  int bad   = 0;
  int cnt;

  banco_registros_param dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_a),
    .wa    (wa_a),
    .wd    (wd_a),
    .ra    (ra_a),
    .rd    (rd_a),
    .pc_in (pc_in_a),
    .clr   (clr_a),
    .busy  (busy_a),
    .pc_wr (pc_wr_a),
    .pc_wd (pc_wd_a)
  );

  banco_registros_param #(
    .DATA_W (16),
    .ADDR_W (3),
    .N_RD   (3)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_b),
    .wa    (wa_b),
    .wd    (wd_b),
    .ra    (ra_b),
    .rd    (rd_b),
    .pc_in (pc_in_b),
    .clr   (clr_b),
    .busy  (busy_b),
    .pc_wr (pc_wr_b),
    .pc_wd (pc_wd_b)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] ra0, input logic [3:0] ra1, input logic clr);
    we_a  = we;
    wa_a  = wa;
    wd_a  = wd;
    ra_a  = {ra1, ra0};
    clr_a = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusB(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                                input logic [2:0] ra2, input logic [2:0] ra1, input logic [2:0] ra0);
    we_b = we;
    wa_b = wa;
    wd_b = wd;
    ra_b = {ra2, ra1, ra0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    we_a = 0; wa_a = 0; wd_a = 0; ra_a = 0; pc_in_a = 0; clr_a = 0;
    we_b = 0; wa_b = 0; wd_b = 0; ra_b = 0; pc_in_b = 0; clr_b = 0;

    #3;
    checkOutput("reset rd_a", rd_a, 64'h0);
    checkOutput("reset busy", {63'h0, busy_a}, 64'h0);
    checkOutput("reset pc_wr", {63'h0, pc_wr_a}, 64'h0);
    checkOutput("reset pc_wd", {32'h0, pc_wd_a}, 64'h0);
    checkOutput("reset rd_b", {16'h0, rd_b}, 64'h0);
    #9;
    rst_n = 1'b1;

    $display("[TB] write then read");
    applyStimulus(1, 4'd3, 32'hDEADBEEF, 4'd0, 4'd0, 0);
    checkOutput("reg0 after reset", {32'h0, rd_a[31:0]}, 64'h0);
    applyStimulus(0, 4'd0, 32'h0, 4'd3, 4'd0, 0);
    checkOutput("write-read rd0", {32'h0, rd_a[31:0]}, 64'hDEADBEEF);

    $display("[TB] bypass");
    applyStimulus(1, 4'd5, 32'h1, 4'd0, 4'd0, 0);
    applyStimulus(1, 4'd5, 32'h12345678, 4'd5, 4'd5, 0);
    checkOutput("bypass rd0", {32'h0, rd_a[31:0]}, 64'h12345678);
    checkOutput("bypass rd1", {32'h0, rd_a[63:32]}, 64'h12345678);
    applyStimulus(0, 4'd0, 32'h0, 4'd5, 4'd3, 0);
    checkOutput("stored after bypass", {32'h0, rd_a[31:0]}, 64'h12345678);
    checkOutput("independent port rd1", {32'h0, rd_a[63:32]}, 64'hDEADBEEF);

    $display("[TB] pc register");
    pc_in_a = 32'h100;
    applyStimulus(0, 4'd0, 32'h0, 4'd3, 4'd15, 0);
    checkOutput("pc read rd1", {32'h0, rd_a[63:32]}, 64'h108);
    applyStimulus(1, 4'd15, 32'h2000, 4'd15, 4'd15, 0);
    checkOutput("pc_wr pulse", {63'h0, pc_wr_a}, 64'h1);
    checkOutput("pc_wd value", {32'h0, pc_wd_a}, 64'h2000);
    checkOutput("pc no bypass rd0", {32'h0, rd_a[31:0]}, 64'h108);
    pc_in_a = 32'hFFFFFFFC;
    applyStimulus(0, 4'd0, 32'h0, 4'd14, 4'd15, 0);
    checkOutput("pc_wr one cycle", {63'h0, pc_wr_a}, 64'h0);
    checkOutput("pc wrap rd1", {32'h0, rd_a[63:32]}, 64'h4);
    checkOutput("reg14 untouched", {32'h0, rd_a[31:0]}, 64'h0);
    pc_in_a = 32'h100;

    $display("[TB] clear sequence");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1, 4'(i), 32'h100 + 32'(i), 4'd0, 4'd0, 0);
    end
    applyStimulus(0, 4'd0, 32'h0, 4'd2, 4'd14, 0);
    checkOutput("fill reg2", {32'h0, rd_a[31:0]}, 64'h102);
    checkOutput("fill reg14", {32'h0, rd_a[63:32]}, 64'h10E);
    applyStimulus(0, 4'd0, 32'h0, 4'd2, 4'd15, 1);
    checkOutput("busy after clr", {63'h0, busy_a}, 64'h1);
    cnt = 0;
    for (int c = 0; c < 40 && busy_a; c++) begin
      cnt++;
      if (cnt == 3) checkOutput("no bypass while busy", {32'h0, rd_a[31:0]}, 64'h102);
      if (cnt == 6) checkOutput("no pc_wr while busy", {63'h0, pc_wr_a}, 64'h0);
      if (cnt == 2)      applyStimulus(1, 4'd2, 32'hAAAA, 4'd2, 4'd15, 0);
      else if (cnt == 5) applyStimulus(1, 4'd15, 32'h3333, 4'd2, 4'd15, 1);
      else               applyStimulus(0, 4'd0, 32'h0, 4'd2, 4'd15, 0);
    end
    checkOutput("busy length", 64'(cnt), 64'd15);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 4'd0, 32'h0, 4'(i), 4'(i), 0);
      checkOutput("cleared reg", {32'h0, rd_a[31:0]}, 64'h0);
    end

    $display("[TB] clr beats write");
    applyStimulus(1, 4'd4, 32'h5555, 4'd4, 4'd4, 1);
    checkOutput("clr+we busy", {63'h0, busy_a}, 64'h1);
    checkOutput("clr+we no bypass", {32'h0, rd_a[31:0]}, 64'h0);
    for (int c = 0; c < 40 && busy_a; c++) begin
      applyStimulus(0, 4'd0, 32'h0, 4'd4, 4'd4, 0);
    end
    checkOutput("drain done", {63'h0, busy_a}, 64'h0);

    $display("[TB] reset mid-clear");
    applyStimulus(1, 4'd9, 32'h99, 4'd9, 4'd15, 0);
    applyStimulus(0, 4'd0, 32'h0, 4'd9, 4'd15, 1);
    cnt = 1;
    for (int c = 0; c < 40 && busy_a && cnt < 7; c++) begin
      applyStimulus(0, 4'd0, 32'h0, 4'd9, 4'd15, 0);
      cnt++;
    end
    checkOutput("busy at cycle 7", {63'h0, busy_a}, 64'h1);
    checkOutput("rd1 pc before reset", {32'h0, rd_a[63:32]}, 64'h108);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", {63'h0, busy_a}, 64'h0);
    checkOutput("async reset rd", rd_a, 64'h0);
    #3;
    rst_n = 1'b1;
    applyStimulus(1, 4'd1, 32'h77, 4'd1, 4'd0, 0);
    checkOutput("first edge after reset", {32'h0, rd_a[31:0]}, 64'h77);
    checkOutput("idle after reset", {63'h0, busy_a}, 64'h0);
    applyStimulus(0, 4'd0, 32'h0, 4'd9, 4'd15, 1);
    checkOutput("reg9 reset", {32'h0, rd_a[31:0]}, 64'h0);
    cnt = 0;
    for (int c = 0; c < 40 && busy_a; c++) begin
      cnt++;
      applyStimulus(0, 4'd0, 32'h0, 4'd9, 4'd15, 0);
    end
    checkOutput("full clear after reset", 64'(cnt), 64'd15);

    $display("[TB] narrow instance");
    pc_in_b = 16'h0100;
    applyStimulusB(1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 3'd0);
    applyStimulusB(0, 3'd0, 16'h0, 3'd3, 3'd0, 3'd7);
    checkOutput("B port0 pc", {48'h0, rd_b[15:0]}, 64'h0108);
    checkOutput("B port1 reg0", {48'h0, rd_b[31:16]}, 64'h0);
    checkOutput("B port2 reg3", {48'h0, rd_b[47:32]}, 64'hBEEF);
    applyStimulusB(1, 3'd5, 16'h1, 3'd0, 3'd0, 3'd0);
    applyStimulusB(1, 3'd5, 16'h1234, 3'd5, 3'd5, 3'd5);
    checkOutput("B bypass all", {16'h0, rd_b}, 64'h123412341234);
    applyStimulusB(1, 3'd7, 16'h2222, 3'd6, 3'd5, 3'd7);
    checkOutput("B pc_wr", {63'h0, pc_wr_b}, 64'h1);
    checkOutput("B pc_wd", {48'h0, pc_wd_b}, 64'h2222);
    checkOutput("B mixed ports", {16'h0, rd_b}, 64'h000012340108);
    pc_in_b = 16'hFFF9;
    applyStimulusB(0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd7);
    checkOutput("B pc wrap", {48'h0, rd_b[15:0]}, 64'h0001);
    checkOutput("B pc_wr cleared", {63'h0, pc_wr_b}, 64'h0);
    checkOutput("B busy idle", {63'h0, busy_b}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banco_registros_param.md
BANCO_REGISTROS_PARAM -- requirements
Module: banco_registros_param

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_W, default 32, register width in bits.
- ADDR_W, default 4, address width; DEPTH = 2**ADDR_W registers.
- N_RD, default 2, number of read ports.

REQ-002 The block SHALL expose these ports (name, direction, width, meaning); one clock, reset is asynchronous and active-low:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable, active-high.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- ra  in  N_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd  out  N_RD*DATA_W  packed registered read data, same packing as ra.
- pc_in  in  DATA_W  current program counter from fetch.
- clr  in  1  single-cycle request to zero the whole file.
- busy  out  1  high while a clear sequence runs.
- pc_wr  out  1  one-cycle pulse: a write targeted the top register.
- pc_wd  out  DATA_W  data accompanying pc_wr.

Function
REQ-003 Address DEPTH-1 (PC) SHALL NOT be storage; a read of it SHALL return pc_in + 8 (mod 2**DATA_W), sampled at the read edge.
REQ-004 Addresses 0..DEPTH-2 SHALL be storage registers.
REQ-005 Reads SHALL have 1-cycle latency: rd port k at edge n+1 reflects ra port k sampled at edge n.
REQ-006 If we=1, busy=0, wa==ra[k] and wa!=DEPTH-1 in the same cycle, rd[k] SHALL return wd (write-first bypass), not the old contents.
REQ-007 A write with we=1, busy=0, wa<DEPTH-1 SHALL update register wa at the rising edge.
REQ-008 A write with we=1, busy=0, wa==DEPTH-1 SHALL leave storage unchanged.
- The next cycle it SHALL assert pc_wr=1 with pc_wd=wd.
- pc_wr SHALL be 0 in all other cycles.
REQ-009 Multiple read ports SHALL be independent; any ports may address the same register.
REQ-010 The clear FSM SHALL have two states, IDLE and CLEAR.
- IDLE to CLEAR on clr=1; a pointer loads 0.
- In CLEAR, one register per cycle (index = pointer) SHALL be zeroed and the pointer incremented.
- After zeroing index DEPTH-2 the FSM SHALL return to IDLE; CLEAR lasts exactly DEPTH-1 cycles.
REQ-011 busy SHALL be high in exactly the cycles the FSM is in CLEAR, registered.
REQ-012 While busy=1, writes SHALL be ignored: no storage change, no pc_wr, no bypass. Reads continue and return current contents, cleared or not.
REQ-013 clr while busy=1 SHALL be ignored; no restart.
REQ-014 clr and we in the same IDLE cycle: clr SHALL win and the write SHALL be dropped.
REQ-015 Pointer arithmetic SHALL be ADDR_W bits with no wrap beyond DEPTH-2.

Reset
REQ-016 On rst_n=0, asynchronously:
- all storage registers SHALL be 0;
- rd SHALL be 0 on every port;
- busy=0, pc_wr=0, pc_wd=0;
- FSM SHALL be IDLE, pointer 0.
REQ-017 Reset asserted mid-CLEAR SHALL abort the sequence; the block SHALL resume in IDLE after release.
REQ-018 The first active edge after rst_n rises SHALL operate normally.

Structure
REQ-019 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the constant PC_OFFSET = 8.
REQ-020 One sub-module, banco_read_port, SHALL implement a single registered read port with bypass and PC substitution. It SHALL be instantiated N_RD times via generate.

Verification
REQ-021 Write then read:
- Stimulus: we=1, wa=3, wd=0xDEADBEEF; next cycle ra0=3.
- Response: rd0=0xDEADBEEF one cycle after ra0 is presented.

REQ-022 Bypass:
- Stimulus: same cycle we=1, wa=5, wd=0x12345678, ra0=5, ra1=5; register 5 previously 0x1.
- Response: rd0 = rd1 = 0x12345678 next cycle.

REQ-023 PC:
- Stimulus: pc_in=0x100, ra1=15; then we=1, wa=15, wd=0x2000.
- Response: rd1=0x108. Then pc_wr=1 for one cycle with pc_wd=0x2000. A later read of 15 still returns pc_in+8.

REQ-024 Clear:
- Stimulus: fill registers 0..14 with nonzero values; pulse clr; issue we=1, wa=2 during busy; pulse clr again at busy cycle 5.
- Response: busy high exactly 15 cycles; all registers 0 afterwards; register 2 stays 0; the second clr has no effect.

REQ-025 Reset mid-clear:
- Stimulus: assert rst_n=0 at busy cycle 7.
- Response: busy=0, all rd=0 immediately. After release a clr starts a full 15-cycle sequence.

REQ-026 Parameter sweep:
- Stimulus: repeat REQ-021 to REQ-022 with DATA_W=16, ADDR_W=3, N_RD=3.
- Response: correct per-port packing; the PC is at address 7.
